// File: rtl/bpseq_pkg.sv
// Shared types for the back-propagation layer sequencer.
package bpseq_pkg;

  localparam int unsigned N_IN = 32;

  typedef logic [31:0] word_t;
  typedef word_t [N_IN-1:0] vec_t;
  typedef word_t [N_IN:0]   row_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WAIT,
    S_CAP,
    S_EVAL,
    S_WB,
    S_DONE
  } state_t;

endpackage

// File: rtl/bpseq_acc.sv
// 32-lane previous-layer error accumulator with clear and add-enable.
// BPSEQ_SAT_ACC_EN selects per-lane saturating adds plus a sticky sat_flag.
module bpseq_acc
  import bpseq_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic add,
  input  vec_t din,
  output vec_t sum
`ifdef BPSEQ_SAT_ACC_EN
  ,
  output logic sat_flag
`endif
);

`ifdef BPSEQ_SAT_ACC_EN
  vec_t            nxt;
  logic [N_IN-1:0] ovf;

  // Overflow only when both operands share a sign that the raw sum loses.
  always_comb begin
    nxt = '0;
    ovf = '0;
    for (int unsigned i = 0; i < N_IN; i++) begin
      nxt[i] = sum[i] + din[i];
      if ((sum[i][31] == din[i][31]) && (nxt[i][31] != sum[i][31])) begin
        ovf[i] = 1'b1;
        nxt[i] = sum[i][31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      sum      <= '0;
      sat_flag <= 1'b0;
    end else if (add) begin
      sum <= nxt;
      if (|ovf) sat_flag <= 1'b1;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      sum <= '0;
    end else if (add) begin
      for (int unsigned i = 0; i < N_IN; i++) begin
        sum[i] <= sum[i] + din[i];
      end
    end
  end
`endif

endmodule

// File: rtl/backprop_sequencer.sv
// Walks one layer of neurons through the shared back-prop datapath: read row, evaluate, write back, accumulate.
// BPSEQ_SAT_ACC_EN adds saturating bc_sum accumulation and the sat_flag output.
module backprop_sequencer
  import bpseq_pkg::*;
#(
  parameter int NEURONS = 8,
  parameter int RD_LAT  = 1,
  parameter int AW      = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  input  vec_t          cfg_ds,
  input  word_t         cfg_tm,
  input  word_t         cfg_td,
  output logic [AW-1:0] mem_addr,
  output logic          mem_rd_en,
  input  row_t          mem_w_rdata,
  input  word_t         mem_bp_rdata,
  output logic          mem_wr_en,
  output row_t          mem_w_wdata,
  output vec_t          dp_ds,
  output row_t          dp_w,
  output word_t         dp_bp,
  output word_t         dp_tm,
  output word_t         dp_td,
  input  vec_t          dp_bc,
  input  row_t          dp_wn,
  output vec_t          bc_sum
`ifdef BPSEQ_SAT_ACC_EN
  ,
  output logic          sat_flag
`endif
);

  localparam logic [AW-1:0] N_LAST = AW'(NEURONS - 1);
  localparam logic [1:0]    W_LAST = 2'((RD_LAT > 1) ? (RD_LAT - 2) : 0);

  state_t        state;
  logic [AW-1:0] n;
  logic [1:0]    wcnt;
  logic          wr_q;
  vec_t          bc_reg;
  logic          acc_clr;
  logic          acc_add;

  assign acc_clr = (state == S_IDLE) && start;
  assign acc_add = (state == S_WB);

  // Strobe is registered, but gated by rst so a reset landing in WB kills that cycle's write.
  assign mem_wr_en = wr_q & ~rst;

  // Strobes are set on the edge entering their state so they are high during it;
  // done is set on the edge leaving DONE, so it pulses the cycle after.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      n           <= '0;
      wcnt        <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      mem_addr    <= '0;
      mem_rd_en   <= 1'b0;
      wr_q        <= 1'b0;
      mem_w_wdata <= '0;
      dp_ds       <= '0;
      dp_w        <= '0;
      dp_bp       <= '0;
      dp_tm       <= '0;
      dp_td       <= '0;
      bc_reg      <= '0;
    end else begin
      done      <= 1'b0;
      mem_rd_en <= 1'b0;
      wr_q      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            dp_ds     <= cfg_ds;
            dp_tm     <= cfg_tm;
            dp_td     <= cfg_td;
            n         <= '0;
            busy      <= 1'b1;
            mem_addr  <= '0;
            mem_rd_en <= 1'b1;
            state     <= S_RD;
          end
        end
        S_RD: begin
          wcnt  <= '0;
          state <= (RD_LAT > 1) ? S_WAIT : S_CAP;
        end
        S_WAIT: begin
          if (wcnt == W_LAST) state <= S_CAP;
          else                wcnt  <= wcnt + 1'b1;
        end
        S_CAP: begin
          dp_w  <= mem_w_rdata;
          dp_bp <= mem_bp_rdata;
          state <= S_EVAL;
        end
        S_EVAL: begin
          mem_w_wdata <= dp_wn;
          bc_reg      <= dp_bc;
          mem_addr    <= n;
          wr_q        <= 1'b1;
          state       <= S_WB;
        end
        S_WB: begin
          if (n == N_LAST) begin
            busy  <= 1'b0;
            state <= S_DONE;
          end else begin
            n         <= n + 1'b1;
            mem_addr  <= n + 1'b1;
            mem_rd_en <= 1'b1;
            state     <= S_RD;
          end
        end
        S_DONE: begin
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  bpseq_acc u_acc (
    .clk      (clk),
    .rst      (rst),
    .clr      (acc_clr),
    .add      (acc_add),
    .din      (bc_reg),
    .sum      (bc_sum)
`ifdef BPSEQ_SAT_ACC_EN
    ,
    .sat_flag (sat_flag)
`endif
  );

endmodule

// File: tb/tb_backprop_sequencer.sv
// Directed bench for backprop_sequencer: two instances (4 neurons / RD_LAT 1, 2 neurons / RD_LAT 3)
// with RAM models and a datapath stub wn=w+bp, bc=ds. Honours BPSEQ_SAT_ACC_EN.
module tb_backprop_sequencer;
  import bpseq_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ovl = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic  rst, start_a, start_b, ld_a, ld_b;
  vec_t  cfg_ds;
  word_t cfg_tm, cfg_td;

  logic busy_a, done_a, rd_a, wr_a, busy_b, done_b, rd_b, wr_b;
  logic [7:0] addr_a, addr_b;
  row_t  rdata_a, wdata_a, dpw_a, dpwn_a, rdata_b, wdata_b, dpw_b, dpwn_b;
  word_t bprd_a, dpbp_a, dptm_a, dptd_a, bprd_b, dpbp_b, dptm_b, dptd_b;
  vec_t  dpds_a, dpbc_a, bcsum_a, dpds_b, dpbc_b, bcsum_b;
`ifdef BPSEQ_SAT_ACC_EN
  logic satf_a, satf_b;
`endif

  backprop_sequencer #(.NEURONS(4), .RD_LAT(1), .AW(8)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .busy(busy_a), .done(done_a),
    .cfg_ds(cfg_ds), .cfg_tm(cfg_tm), .cfg_td(cfg_td),
    .mem_addr(addr_a), .mem_rd_en(rd_a), .mem_w_rdata(rdata_a), .mem_bp_rdata(bprd_a),
    .mem_wr_en(wr_a), .mem_w_wdata(wdata_a),
    .dp_ds(dpds_a), .dp_w(dpw_a), .dp_bp(dpbp_a), .dp_tm(dptm_a), .dp_td(dptd_a),
    .dp_bc(dpbc_a), .dp_wn(dpwn_a), .bc_sum(bcsum_a)
`ifdef BPSEQ_SAT_ACC_EN
    , .sat_flag(satf_a)
`endif
  );

  backprop_sequencer #(.NEURONS(2), .RD_LAT(3), .AW(8)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b),
    .cfg_ds(cfg_ds), .cfg_tm(cfg_tm), .cfg_td(cfg_td),
    .mem_addr(addr_b), .mem_rd_en(rd_b), .mem_w_rdata(rdata_b), .mem_bp_rdata(bprd_b),
    .mem_wr_en(wr_b), .mem_w_wdata(wdata_b),
    .dp_ds(dpds_b), .dp_w(dpw_b), .dp_bp(dpbp_b), .dp_tm(dptm_b), .dp_td(dptd_b),
    .dp_bc(dpbc_b), .dp_wn(dpwn_b), .bc_sum(bcsum_b)
`ifdef BPSEQ_SAT_ACC_EN
    , .sat_flag(satf_b)
`endif
  );

  always_comb begin
    dpwn_a = '0; dpbc_a = '0; dpwn_b = '0; dpbc_b = '0;
    for (int i = 0; i < 33; i++) begin
      dpwn_a[i] = dpw_a[i] + dpbp_a;
      dpwn_b[i] = dpw_b[i] + dpbp_b;
    end
    for (int i = 0; i < 32; i++) begin
      dpbc_a[i] = dpds_a[i];
      dpbc_b[i] = dpds_b[i];
    end
  end

  row_t  ram_a [4];
  word_t bpm_a [4];
  always @(posedge clk) begin
    if (ld_a) begin
      for (int k = 0; k < 4; k++) begin
        ram_a[k] <= {33{32'(k)}};
        bpm_a[k] <= 32'd10;
      end
    end else if (wr_a) begin
      ram_a[addr_a[1:0]] <= wdata_a;
    end
    if (rd_a) begin
      rdata_a <= ram_a[addr_a[1:0]];
      bprd_a  <= bpm_a[addr_a[1:0]];
    end
  end

  row_t  ram_b [2];
  word_t bpm_b [2];
  row_t  p1r_b, p2r_b;
  word_t p1b_b, p2b_b;
  word_t wlog_b [$];
  always @(posedge clk) begin
    if (ld_b) begin
      for (int k = 0; k < 2; k++) begin
        ram_b[k] <= {33{32'(100 + k)}};
        bpm_b[k] <= 32'd5;
      end
    end else if (wr_b) begin
      ram_b[addr_b[0]] <= wdata_b;
      wlog_b.push_back(32'(addr_b));
    end
    if (rd_b) begin
      p1r_b <= ram_b[addr_b[0]];
      p1b_b <= bpm_b[addr_b[0]];
    end
    p2r_b   <= p1r_b;
    p2b_b   <= p1b_b;
    rdata_b <= p2r_b;
    bprd_b  <= p2b_b;
  end

  always @(negedge clk) begin
    if ((rd_a && wr_a) || (rd_b && wr_b)) ovl <= ovl + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic reload();
    @(negedge clk);
    ld_a = 1'b1;
    ld_b = 1'b1;
    @(negedge clk);
    ld_a = 1'b0;
    ld_b = 1'b0;
  endtask

  // Runs one pass on instance A; perturb re-raises start and changes cfg_tm mid-pass.
  task automatic run_a(input bit perturb, output int lat, output int busy_n, output int tm_bad);
    int    t0;
    word_t tm0;
    bit    seen;
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    t0 = cyc; tm0 = cfg_tm; lat = -1; busy_n = 0; tm_bad = 0; seen = 1'b0;
    for (int c = 0; c < 200 && !seen; c++) begin
      if (busy_a) busy_n++;
      if (busy_a && dptm_a !== tm0) tm_bad++;
      if (done_a) begin
        lat  = cyc - t0;
        seen = 1'b1;
      end else begin
        if (perturb && c == 5) begin start_a = 1'b1; cfg_tm = ~tm0; end
        if (perturb && c == 6) start_a = 1'b0;
        @(negedge clk);
      end
    end
    cfg_tm = tm0;
  endtask

  task automatic check_pass_a();
    for (int k = 0; k < 4; k++)
      for (int w = 0; w < 33; w++)
        check_val("row_a", ram_a[k][w], 32'(k + 10));
    for (int i = 0; i < 32; i++) check_val("bcsum_a", bcsum_a[i], 32'(4 * i));
  endtask

  initial begin
    int  lat, bn, tb_n;
    bit  hit;
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; ld_a = 1'b0; ld_b = 1'b0;
    for (int i = 0; i < 32; i++) cfg_ds[i] = 32'(i);
    cfg_tm = 32'h1234_5678;
    cfg_td = 32'h0000_ABCD;
    repeat (3) @(negedge clk);
    check_val("rst_busy", 32'(busy_a), 0);
    check_val("rst_done", 32'(done_a), 0);
    check_val("rst_rd", 32'(rd_a), 0);
    check_val("rst_wr", 32'(wr_a), 0);
    check_val("rst_addr", 32'(addr_a), 0);
    check_val("rst_dptm", dptm_a, 0);
    check_val("rst_dpds", dpds_a[5], 0);
    check_val("rst_bcsum", bcsum_a[3], 0);
    rst = 1'b0;

    reload();
    run_a(1'b0, lat, bn, tb_n);
    check_val("done_lat_a", 32'(lat), 17);
    check_val("busy_len_a", 32'(bn), 16);
    check_val("dptm_a", dptm_a, 32'h1234_5678);
    check_val("dptd_a", dptd_a, 32'h0000_ABCD);
    check_pass_a();
    @(negedge clk);
    check_val("done_pulse", 32'(done_a), 0);

    reload();
    run_a(1'b1, lat, bn, tb_n);
    check_val("norestart_lat", 32'(lat), 17);
    check_val("tm_stable", 32'(tb_n), 0);
    check_pass_a();

    reload();
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    hit = 1'b0;
    for (int c = 0; c < 100 && !hit; c++) begin
      if (wr_a && addr_a == 8'd1) hit = 1'b1;
      else @(negedge clk);
    end
    check_val("wb1_seen", 32'(hit), 1);
    rst = 1'b1;
    @(negedge clk);
    check_val("mid_state", 32'(dut_a.state), 32'(S_IDLE));
    check_val("mid_busy", 32'(busy_a), 0);
    check_val("mid_wr", 32'(wr_a), 0);
    check_val("mid_addr", 32'(addr_a), 0);
    check_val("mid_dpw", dpw_a[0], 0);
    check_val("mid_dpbp", dpbp_a, 0);
    check_val("mid_dpds", dpds_a[7], 0);
    check_val("mid_wdata", wdata_a[0], 0);
    check_val("mid_bcsum", bcsum_a[1], 0);
    rst = 1'b0;
    check_val("mid_row1", ram_a[1][0], 32'd1);
    check_val("mid_row0", ram_a[0][0], 32'd10);
    reload();
    run_a(1'b0, lat, bn, tb_n);
    check_val("post_rst_lat", 32'(lat), 17);
    check_pass_a();

    cfg_ds[0] = 32'h7FFF_FFFF;
    @(negedge clk);
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    lat = cyc;
    hit = 1'b0;
    for (int c = 0; c < 100 && !hit; c++) begin
      if (done_b) hit = 1'b1;
      else @(negedge clk);
    end
    check_val("done_lat_b", hit ? 32'(cyc - lat) : 32'hFFFF_FFFF, 13);
    check_val("wlog_n", 32'(wlog_b.size()), 2);
    if (wlog_b.size() == 2) begin
      check_val("wlog_0", wlog_b[0], 0);
      check_val("wlog_1", wlog_b[1], 1);
    end
    for (int k = 0; k < 2; k++)
      for (int w = 0; w < 33; w++)
        check_val("row_b", ram_b[k][w], 32'(105 + k));
    check_val("bcsum_b1", bcsum_b[1], 2);
`ifdef BPSEQ_SAT_ACC_EN
    check_val("bcsum_b0", bcsum_b[0], 32'h7FFF_FFFF);
    check_val("sat_flag_b", 32'(satf_b), 1);
    check_val("sat_flag_a", 32'(satf_a), 0);
`else
    check_val("bcsum_b0", bcsum_b[0], 32'hFFFF_FFFE);
`endif
    check_val("rd_wr_overlap", 32'(ovl), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/backprop_sequencer.md
Name: backprop_sequencer

Overview:
- Sequences the combinational 32-input back-propagation datapath over one layer of NEURONS neurons.
- For each neuron it:
  - fetches the 33-word weight row (32 weights + threshold) and the neuron's back-prop error;
  - presents them to the datapath together with the layer-wide bp_ds, bp_tm and bp_td;
  - writes the updated row back;
  - accumulates the per-input bp_bc terms into 32 error sums for the previous layer.
- Sits between weight/error RAMs and one shared datapath instance.

Parameters:
- NEURONS, 8, number of neurons in the layer (1..256)
- RD_LAT, 1, weight/error RAM read latency in cycles (1..4)
- AW, 8, RAM address width; must satisfy 2**AW >= NEURONS

Ports:
- clk  in  1  clock, all logic rising-edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a layer pass; sampled only in IDLE
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse after the last write-back
- cfg_ds  in  32x32  layer derivative vector; sampled at start
- cfg_tm  in  32  learning-rate term; sampled at start
- cfg_td  in  32  delta term; sampled at start
- mem_addr  out  AW  neuron index, shared by read and write
- mem_rd_en  out  1  read strobe
- mem_w_rdata  in  33x32  weight row, valid RD_LAT cycles after mem_rd_en
- mem_bp_rdata  in  32  neuron error, same timing as mem_w_rdata
- mem_wr_en  out  1  write strobe
- mem_w_wdata  out  33x32  updated row
- dp_ds  out  32x32  datapath bp_ds
- dp_w  out  33x32  datapath bp_w
- dp_bp  out  32  datapath bp_bp
- dp_tm  out  32  datapath bp_tm
- dp_td  out  32  datapath bp_td
- dp_bc  in  32x32  datapath bp_bc
- dp_wn  in  33x32  datapath bp_wn
- bc_sum  out  32x32  accumulated previous-layer error

Behaviour:
- Reset values:
  - busy, done, mem_rd_en, mem_wr_en = 0; mem_addr = 0.
  - All dp_* outputs, mem_w_wdata and bc_sum = 0.
  - State = IDLE; neuron counter n = 0.
- FSM states: IDLE, RD, WAIT, CAP, EVAL, WB, DONE.
- IDLE:
  - On start=1: latch cfg_* into dp_ds/dp_tm/dp_td, clear bc_sum to 0, n=0, go to RD.
- RD:
  - mem_addr=n, mem_rd_en=1 for exactly one cycle.
  - Go to WAIT if RD_LAT>1, else CAP.
- WAIT:
  - Held for RD_LAT-1 cycles, then go to CAP.
- CAP:
  - Register mem_w_rdata into dp_w and mem_bp_rdata into dp_bp; go to EVAL.
- EVAL:
  - Datapath settles.
  - At the end of the cycle, register dp_wn into mem_w_wdata and dp_bc into an internal bc_reg; go to WB.
- WB:
  - mem_addr=n, mem_wr_en=1 for one cycle.
  - bc_sum[i] += bc_reg[i] for all i.
  - If n==NEURONS-1 go to DONE, else n++ and go to RD.
- DONE:
  - done=1 for one cycle, busy=0, return to IDLE.
  - bc_sum holds its value until the next accepted start.
- Timing:
  - Per-neuron cost is RD_LAT+3 cycles.
  - The done pulse occurs NEURONS*(RD_LAT+3)+1 cycles after the start-accept edge.
- Arithmetic: bc_sum addition is 32-bit two's complement and wraps on overflow by default. No other arithmetic lives in this block.
- Read and write never overlap: at most one of mem_rd_en / mem_wr_en is high in any cycle.
- start while busy is ignored. start coincident with the DONE cycle is also ignored; it is accepted only in IDLE.
- cfg_* changes during a pass have no effect.
- rst mid-pass:
  - Next cycle is IDLE with every output at its reset value.
  - Any write scheduled for that cycle is suppressed; rst has priority over every state action.
- NEURONS=1: single RD..WB sequence, then DONE.

Optional Feature:
- Macro: BPSEQ_SAT_ACC_EN.
- When defined: bc_sum accumulation saturates at 32'h7FFFFFFF / 32'h80000000 per lane, detected via sign of operands vs result, and an extra output sat_flag (1 bit) goes sticky-high on any saturation. sat_flag is cleared by rst or by an accepted start.
- When undefined: accumulation wraps and the sat_flag port does not exist.

Decomposition:
- Package bpseq_pkg holds:
  - typedef word_t (logic [31:0]);
  - typedef vec_t (word_t [31:0]);
  - typedef row_t (word_t [32:0]);
  - enum state_t for the FSM states;
  - localparam N_IN=32.
- One natural sub-module, bpseq_acc: a 32-lane accumulator with clear and add-enable, and optional saturation under BPSEQ_SAT_ACC_EN. The FSM and memory sequencing stay in the top module.

Test Plan:
- Bench setup: datapath stub with dp_wn[i]=dp_w[i]+dp_bp and dp_bc[i]=dp_ds[i]; RAM model with RD_LAT=1.
- Basic pass:
  - Stimulus: NEURONS=4, row k all words = k, bp[k]=10, cfg_ds[i]=i, start pulse.
  - Required response: RAM row k becomes all k+10; bc_sum[i]=4*i; done exactly 17 cycles after start; busy high for 16 cycles.
- Read latency:
  - Stimulus: RD_LAT=3, NEURONS=2.
  - Required response: done at cycle 13; mem_rd_en and mem_wr_en never high together; writes to addr 0 then addr 1.
- Reset mid-pass:
  - Stimulus: rst asserted in the WB cycle of neuron 1.
  - Required response: no write to addr 1 that cycle; next cycle all outputs are 0 and state is IDLE; a following start gives a correct full pass.
- Start and config stability:
  - Stimulus: start re-asserted while busy, and cfg_tm changed mid-pass.
  - Required response: no restart; dp_tm keeps its start-time value for the whole pass.
- Overflow:
  - Stimulus: dp_bc lane 0 = 32'h7FFFFFFF for two neurons.
  - Required response: bc_sum[0]=32'hFFFFFFFE without the macro; 32'h7FFFFFFF and sat_flag=1 with BPSEQ_SAT_ACC_EN.
